mips_regfile_mp: RTL and testbench

Parametrised multi-port register file for the 32-bit MIPS datapath. It replaces the single-write, dual-read register file with the following:
- configurable data width, depth and read-port count
- two write ports, so writeback and a second retire/load path can commit in one cycle
- a selectable read-during-write mode
- a hardwired zero register
- a write-collision flag

It sits between decode (read addresses) and writeback (write ports).

---
 rtl/mips_regfile_mp.sv | 78 +++++++
 tb/tb_mips_regfile_mp.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_mp.sv
// rtl/mips_regfile_mp.sv - dual-write, multi-read register file with zero register and optional write-first bypass
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en_a,
    input  logic [ADDR_W-1:0]          wr_addr_a,
    input  logic [DATA_W-1:0]          wr_data_a,
    input  logic                       wr_en_b,
    input  logic [ADDR_W-1:0]          wr_addr_b,
    input  logic [DATA_W-1:0]          wr_data_b,
    output logic                       wr_conflict
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    // An address is "live" when it maps to a storage register that can hold a value.
    function automatic logic live(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_X) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] rd_nxt [NUM_RD];
    logic [DATA_W-1:0] rd_q [NUM_RD];
    logic              keep_a;
    logic              keep_b;

    assign keep_a = wr_en_a && live(wr_addr_a);
    assign keep_b = wr_en_b && live(wr_addr_b);

    // Port B is applied last so it wins a same-address double write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (keep_a) regs[wr_addr_a] <= wr_data_a;
            if (keep_b) regs[wr_addr_b] <= wr_data_b;
            wr_conflict <= keep_a && keep_b && (wr_addr_a == wr_addr_b);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_nxt[i] = '0;
            if (live(rd_addr[i*ADDR_W +: ADDR_W])) begin
                rd_nxt[i] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
                if (BYPASS != 0) begin
                    if (keep_b && (wr_addr_b == rd_addr[i*ADDR_W +: ADDR_W]))
                        rd_nxt[i] = wr_data_b;
                    else if (keep_a && (wr_addr_a == rd_addr[i*ADDR_W +: ADDR_W]))
                        rd_nxt[i] = wr_data_a;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RD; i++) rd_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) rd_q[i] <= rd_nxt[i];
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_lane
        assign rd_data[g*DATA_W +: DATA_W] = rd_q[g];
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// tb/tb_mips_regfile_mp.sv - randomized, model-checked bench for mips_regfile_mp in two configurations
module tb_mips_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [9:0]   ra0;
    logic [63:0]  rd0;
    logic [19:0]  ra1;
    logic [127:0] rd1;
    logic         wea, web;
    logic [4:0]   waa, wab;
    logic [31:0]  wda, wdb;
    logic         wc0, wc1;

    int n_checks = 0;
    int n_fail = 0;

    // dut0: default configuration (old-value reads, zero register, 32 entries, 2 lanes)
    mips_regfile_mp dut0 (
        .clk(clk), .rst_n(rst_n), .rd_addr(ra0), .rd_data(rd0),
        .wr_en_a(wea), .wr_addr_a(waa), .wr_data_a(wda),
        .wr_en_b(web), .wr_addr_b(wab), .wr_data_b(wdb),
        .wr_conflict(wc0)
    );

    // dut1: write-first, no zero register, 24 entries, 4 lanes
    mips_regfile_mp #(.DEPTH(24), .NUM_RD(4), .BYPASS(1), .ZERO_REG(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_addr(ra1), .rd_data(rd1),
        .wr_en_a(wea), .wr_addr_a(waa), .wr_data_a(wda),
        .wr_en_b(web), .wr_addr_b(wab), .wr_data_b(wdb),
        .wr_conflict(wc1)
    );

    always #5 clk = ~clk;

    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [31:0] exp0 [2];
    logic [31:0] exp1 [4];
    logic        expc0, expc1;

    function automatic logic ok0(input logic [4:0] a);
        return a != 0;
    endfunction

    function automatic logic ok1(input logic [4:0] a);
        return int'(a) < 24;
    endfunction

    function automatic logic [31:0] want0(input logic [4:0] a);
        return ok0(a) ? m0[a] : 32'h0;
    endfunction

    function automatic logic [31:0] want1(input logic [4:0] a);
        if (!ok1(a)) return 32'h0;
        if (web && wab == a) return wdb;
        if (wea && waa == a) return wda;
        return m1[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m0[i] = 32'h0;
            m1[i] = 32'h0;
        end
    endtask

    // Predict outputs for the coming edge, take the edge, update the model, settle 1 time unit later.
    task automatic step();
        for (int i = 0; i < 2; i++) exp0[i] = want0(ra0[i*5 +: 5]);
        for (int i = 0; i < 4; i++) exp1[i] = want1(ra1[i*5 +: 5]);
        expc0 = wea && web && waa == wab && ok0(waa);
        expc1 = wea && web && waa == wab && ok1(waa);
        @(posedge clk);
        if (wea && ok0(waa)) m0[waa] = wda;
        if (web && ok0(wab)) m0[wab] = wdb;
        if (wea && ok1(waa)) m1[waa] = wda;
        if (web && ok1(wab)) m1[wab] = wdb;
        #1;
    endtask

    task automatic idle();
        wea = 0; web = 0; waa = 0; wab = 0; wda = 0; wdb = 0;
    endtask

    task automatic read_all(input logic [4:0] a);
        ra0 = {a, a};
        ra1 = {a, a, a, a};
    endtask

    task automatic test_reset();
        idle();
        ra0 = 0; ra1 = 0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            wea = 1; waa = 5'(a); wda = $urandom | 32'h1;
            step();
        end
        idle();
        ra0 = {5'd6, 5'd5};
        ra1 = {5'd4, 5'd3, 5'd2, 5'd1};
        wea = 1; web = 1; waa = 7; wab = 7; wda = 32'h1234; wdb = 32'h5678;
        step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (rd0 !== 64'h0) begin n_fail++; $display("FAIL reset_async_rd0 got %h want 0", rd0); end
        n_checks++;
        if (rd1 !== 128'h0) begin n_fail++; $display("FAIL reset_async_rd1 got %h want 0", rd1); end
        n_checks++;
        if (wc0 !== 1'b0 || wc1 !== 1'b0) begin n_fail++; $display("FAIL reset_async_conflict got %b%b want 00", wc0, wc1); end
        #1 rst_n = 1'b1;
        for (int a = 1; a < 32; a++) begin
            read_all(5'(a));
            step();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (rd0[i*32 +: 32] !== 32'h0) begin n_fail++; $display("FAIL reset_clear0 r%0d lane%0d got %h want 0", a, i, rd0[i*32 +: 32]); end
            end
            n_checks++;
            if (rd1[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_clear1 r%0d got %h want 0", a, rd1[31:0]); end
        end
    endtask

    task automatic test_basic();
        idle();
        wea = 1; waa = 5; wda = 32'hDEADBEEF;
        step();
        idle();
        ra0 = {5'd0, 5'd5};
        ra1 = {5'd0, 5'd0, 5'd0, 5'd5};
        step();
        n_checks++;
        if (rd0[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd0 got %h want deadbeef", rd0[31:0]); end
        n_checks++;
        if (rd1[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd1 got %h want deadbeef", rd1[31:0]); end
    endtask

    task automatic test_dual_write();
        idle();
        wea = 1; waa = 3; wda = 32'h11;
        web = 1; wab = 4; wdb = 32'h22;
        step();
        n_checks++;
        if (wc0 !== 1'b0 || wc1 !== 1'b0) begin n_fail++; $display("FAIL dual_diff_conflict got %b%b want 00", wc0, wc1); end
        idle();
        ra0 = {5'd4, 5'd3};
        ra1 = {5'd4, 5'd3, 5'd4, 5'd3};
        step();
        n_checks++;
        if (rd0 !== {32'h22, 32'h11}) begin n_fail++; $display("FAIL dual_diff_rd0 got %h want 0000002200000011", rd0); end
        n_checks++;
        if (rd1 !== {32'h22, 32'h11, 32'h22, 32'h11}) begin n_fail++; $display("FAIL dual_diff_rd1 got %h", rd1); end
        wea = 1; waa = 7; wda = 32'hAAAA;
        web = 1; wab = 7; wdb = 32'hBBBB;
        step();
        n_checks++;
        if (wc0 !== 1'b1 || wc1 !== 1'b1) begin n_fail++; $display("FAIL dual_same_conflict got %b%b want 11", wc0, wc1); end
        idle();
        read_all(5'd7);
        step();
        n_checks++;
        if (wc0 !== 1'b0 || wc1 !== 1'b0) begin n_fail++; $display("FAIL dual_same_conflict_drop got %b%b want 00", wc0, wc1); end
        n_checks++;
        if (rd0[31:0] !== 32'hBBBB || rd1[31:0] !== 32'hBBBB) begin n_fail++; $display("FAIL dual_same_data got %h/%h want bbbb", rd0[31:0], rd1[31:0]); end
        wea = 1; waa = 0; wda = 32'hAAAA;
        web = 1; wab = 0; wdb = 32'hBBBB;
        step();
        n_checks++;
        if (wc0 !== 1'b0 || wc1 !== 1'b1) begin n_fail++; $display("FAIL dual_r0_conflict got %b%b want 01", wc0, wc1); end
        idle();
        read_all(5'd0);
        step();
        n_checks++;
        if (rd0[31:0] !== 32'h0 || rd1[31:0] !== 32'hBBBB) begin n_fail++; $display("FAIL dual_r0_data got %h/%h want 0/bbbb", rd0[31:0], rd1[31:0]); end
        wea = 1; waa = 30; wda = 32'h1;
        web = 1; wab = 30; wdb = 32'h2;
        step();
        n_checks++;
        if (wc0 !== 1'b1 || wc1 !== 1'b0) begin n_fail++; $display("FAIL dual_oor_conflict got %b%b want 10", wc0, wc1); end
    endtask

    task automatic test_read_during_write();
        idle();
        wea = 1; waa = 9; wda = 32'h1;
        step();
        ra0 = {5'd9, 5'd0};
        ra1 = {5'd0, 5'd0, 5'd9, 5'd0};
        wea = 1; waa = 9; wda = 32'h2;
        step();
        n_checks++;
        if (rd0[63:32] !== 32'h1) begin n_fail++; $display("FAIL rdw_old got %h want 1", rd0[63:32]); end
        n_checks++;
        if (rd1[63:32] !== 32'h2) begin n_fail++; $display("FAIL rdw_bypass got %h want 2", rd1[63:32]); end
        idle();
        step();
        n_checks++;
        if (rd0[63:32] !== 32'h2) begin n_fail++; $display("FAIL rdw_next got %h want 2", rd0[63:32]); end
        wea = 1; waa = 9; wda = 32'h3;
        web = 1; wab = 9; wdb = 32'h4;
        step();
        n_checks++;
        if (rd1[63:32] !== 32'h4 || rd0[63:32] !== 32'h2) begin n_fail++; $display("FAIL rdw_dual got %h/%h want 4/2", rd1[63:32], rd0[63:32]); end
    endtask

    task automatic test_zero_and_range();
        idle();
        wea = 1; waa = 0; wda = 32'hFFFF;
        step();
        idle();
        read_all(5'd0);
        step();
        n_checks++;
        if (rd0[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_reg got %h want 0", rd0[31:0]); end
        n_checks++;
        if (rd1[31:0] !== 32'hFFFF) begin n_fail++; $display("FAIL zero_plain got %h want ffff", rd1[31:0]); end
        web = 1; wab = 30; wdb = 32'h5;
        step();
        idle();
        read_all(5'd30);
        step();
        n_checks++;
        if (rd1 !== 128'h0) begin n_fail++; $display("FAIL range_read got %h want 0", rd1); end
        n_checks++;
        if (rd0[31:0] !== 32'h5) begin n_fail++; $display("FAIL range_full got %h want 5", rd0[31:0]); end
        for (int a = 0; a < 24; a++) begin
            read_all(5'(a));
            step();
            n_checks++;
            if (rd1[31:0] !== exp1[0]) begin n_fail++; $display("FAIL range_keep r%0d got %h want %h", a, rd1[31:0], exp1[0]); end
        end
        wea = 1; waa = 2; wda = $urandom;
        step();
        idle();
        read_all(5'd2);
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd1[i*32 +: 32] !== m1[2]) begin n_fail++; $display("FAIL lanes_same lane%0d got %h want %h", i, rd1[i*32 +: 32], m1[2]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wea = 1'($urandom); web = 1'($urandom);
            waa = 5'($urandom); wab = ($urandom_range(0, 3) == 0) ? waa : 5'($urandom);
            wda = $urandom; wdb = $urandom;
            ra0 = 10'($urandom);
            ra1 = 20'($urandom);
            if ($urandom_range(0, 3) == 0) ra1[4:0] = waa;
            step();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (rd0[i*32 +: 32] !== exp0[i]) begin n_fail++; $display("FAIL rand_rd0 c%0d lane%0d got %h want %h", c, i, rd0[i*32 +: 32], exp0[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (rd1[i*32 +: 32] !== exp1[i]) begin n_fail++; $display("FAIL rand_rd1 c%0d lane%0d got %h want %h", c, i, rd1[i*32 +: 32], exp1[i]); end
            end
            n_checks++;
            if (wc0 !== expc0 || wc1 !== expc1) begin n_fail++; $display("FAIL rand_conflict c%0d got %b%b want %b%b", c, wc0, wc1, expc0, expc1); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dual_write();
        test_read_during_write();
        test_zero_and_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
